// File: rtl/lcd_sprite_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lcd_sprite_scheduler
// Brief    : Per-frame sprite motion scheduler with host write and render read
// Revision : 1.0 - initial release
// ============================================================================
module lcd_sprite_scheduler #(
    parameter int NUM_SPRITES = 8,
    parameter int H_VALID     = 480,
    parameter int V_VALID     = 272,
    parameter int XW          = 10,
    parameter int YW          = 9,
    parameter int VW          = 4,
    localparam int IW         = $clog2(NUM_SPRITES)
) (
    input  logic          PixelClk,
    input  logic          nRST,
    input  logic          frame_start,
    input  logic          host_req,
    input  logic [IW-1:0] host_idx,
    input  logic [XW-1:0] host_x,
    input  logic [YW-1:0] host_y,
    input  logic [VW-1:0] host_dx,
    input  logic [VW-1:0] host_dy,
    output logic          host_ack,
    input  logic [IW-1:0] rd_idx,
    output logic [XW-1:0] rd_x,
    output logic [YW-1:0] rd_y,
    output logic          busy,
    output logic          update_done,
    output logic          overrun
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_UPDATE = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [XW-1:0] C_H_VALID = XW'(H_VALID);
    localparam logic [YW-1:0] C_V_VALID = YW'(V_VALID);
    localparam logic [IW-1:0] C_LAST    = IW'(NUM_SPRITES - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [IW-1:0] r_cnt;
    logic          r_ack_prev;
    logic          r_overrun;
    logic [XW-1:0] r_rd_x;
    logic [YW-1:0] r_rd_y;

    logic [XW-1:0] r_x_mem  [NUM_SPRITES];
    logic [YW-1:0] r_y_mem  [NUM_SPRITES];
    logic [VW-1:0] r_dx_mem [NUM_SPRITES];
    logic [VW-1:0] r_dy_mem [NUM_SPRITES];

    logic [XW:0]   w_sum_x;
    logic [YW:0]   w_sum_y;
    logic [XW-1:0] w_next_x;
    logic [YW-1:0] w_next_y;

    // State register
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_ack_prev <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ack_prev <= host_ack;
            if (frame_start && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (r_state == S_UPDATE) begin
                r_cnt <= r_cnt + IW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (frame_start) w_state_next = S_UPDATE;
            S_UPDATE: if (r_cnt == C_LAST) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Output logic; a pending host write yields to frame_start and to the previous ack
    always_comb begin
        busy        = (r_state != S_IDLE);
        update_done = (r_state == S_DONE);
        host_ack    = (r_state == S_IDLE) && host_req && !frame_start && !r_ack_prev;
    end

    // Wrap: the extra top bit of the sum is the sign; the add/subtract is done mod 2^W
    always_comb begin
        w_sum_x = {1'b0, r_x_mem[r_cnt]} + {{(XW + 1 - VW){r_dx_mem[r_cnt][VW-1]}}, r_dx_mem[r_cnt]};
        w_sum_y = {1'b0, r_y_mem[r_cnt]} + {{(YW + 1 - VW){r_dy_mem[r_cnt][VW-1]}}, r_dy_mem[r_cnt]};

        if (w_sum_x[XW]) begin
            w_next_x = w_sum_x[XW-1:0] + C_H_VALID;
        end else if (w_sum_x >= {1'b0, C_H_VALID}) begin
            w_next_x = w_sum_x[XW-1:0] - C_H_VALID;
        end else begin
            w_next_x = w_sum_x[XW-1:0];
        end

        if (w_sum_y[YW]) begin
            w_next_y = w_sum_y[YW-1:0] + C_V_VALID;
        end else if (w_sum_y >= {1'b0, C_V_VALID}) begin
            w_next_y = w_sum_y[YW-1:0] - C_V_VALID;
        end else begin
            w_next_y = w_sum_y[YW-1:0];
        end
    end

    // Attribute table
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_x_mem[i]  <= '0;
                r_y_mem[i]  <= '0;
                r_dx_mem[i] <= '0;
                r_dy_mem[i] <= '0;
            end
        end else if (r_state == S_UPDATE) begin
            r_x_mem[r_cnt] <= w_next_x;
            r_y_mem[r_cnt] <= w_next_y;
        end else if (host_ack) begin
            r_x_mem[host_idx]  <= host_x;
            r_y_mem[host_idx]  <= host_y;
            r_dx_mem[host_idx] <= host_dx;
            r_dy_mem[host_idx] <= host_dy;
        end
    end

    // Renderer read port
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            r_rd_x <= '0;
            r_rd_y <= '0;
        end else begin
            r_rd_x <= r_x_mem[rd_idx];
            r_rd_y <= r_y_mem[rd_idx];
        end
    end

    assign rd_x    = r_rd_x;
    assign rd_y    = r_rd_y;
    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_lcd_sprite_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_sprite_scheduler
// Brief    : Scoreboard bench for lcd_sprite_scheduler against a motion model
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_sprite_scheduler;

    localparam int N  = 8;
    localparam int H  = 480;
    localparam int V  = 272;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int VW = 4;
    localparam int IW = 3;

    logic          PixelClk = 1'b0;
    logic          nRST = 1'b0;
    logic          frame_start = 1'b0;
    logic          host_req = 1'b0;
    logic [IW-1:0] host_idx = '0;
    logic [XW-1:0] host_x = '0;
    logic [YW-1:0] host_y = '0;
    logic [VW-1:0] host_dx = '0;
    logic [VW-1:0] host_dy = '0;
    logic          host_ack;
    logic [IW-1:0] rd_idx = '0;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic          busy;
    logic          update_done;
    logic          overrun;

    lcd_sprite_scheduler #(
        .NUM_SPRITES(N), .H_VALID(H), .V_VALID(V), .XW(XW), .YW(YW), .VW(VW)
    ) dut (
        .PixelClk(PixelClk), .nRST(nRST), .frame_start(frame_start),
        .host_req(host_req), .host_idx(host_idx), .host_x(host_x), .host_y(host_y),
        .host_dx(host_dx), .host_dy(host_dy), .host_ack(host_ack),
        .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y),
        .busy(busy), .update_done(update_done), .overrun(overrun)
    );

    always #5 PixelClk = ~PixelClk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference table, signed velocities held as plain ints
    int mx [N];
    int my [N];
    int mdx[N];
    int mdy[N];

    int exp_x_q[$];
    int exp_y_q[$];
    int exp_i_q[$];

    logic rd_req = 1'b0;
    logic chk_q  = 1'b0;
    logic prev_ack = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int wrapv(input int s, input int m);
        if (s < 0) return s + m;
        if (s >= m) return s - m;
        return s;
    endfunction

    function automatic void model_step();
        for (int i = 0; i < N; i++) begin
            mx[i] = wrapv(mx[i] + mdx[i], H);
            my[i] = wrapv(my[i] + mdy[i], V);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) begin
            mx[i] = 0; my[i] = 0; mdx[i] = 0; mdy[i] = 0;
        end
    endfunction

    function automatic void model_write(input int i, input int x, input int y, input int dx, input int dy);
        mx[i] = x; my[i] = y; mdx[i] = dx; mdy[i] = dy;
    endfunction

    // Read monitor: one cycle after a read request the registered port must match
    always @(posedge PixelClk) chk_q <= rd_req;

    always @(negedge PixelClk) begin
        if (chk_q) begin
            if (exp_x_q.size() == 0) begin
                check("rd_unexpected", 1, 0);
            end else begin
                int ex, ey, ei;
                ex = exp_x_q.pop_front();
                ey = exp_y_q.pop_front();
                ei = exp_i_q.pop_front();
                check($sformatf("rd_x[%0d]", ei), int'(rd_x), ex);
                check($sformatf("rd_y[%0d]", ei), int'(rd_y), ey);
            end
        end
    end

    // Handshake monitor: no back-to-back acks, never ack together with update_done
    always @(negedge PixelClk) begin
        if (nRST && host_ack) begin
            check("ack_not_consecutive", int'(prev_ack), 0);
            check("ack_not_with_done", int'(update_done), 0);
        end
        prev_ack = host_ack;
    end

    task automatic do_read(input int idx);
        @(posedge PixelClk); #1;
        rd_idx = IW'(idx);
        rd_req = 1'b1;
        exp_x_q.push_back(mx[idx]);
        exp_y_q.push_back(my[idx]);
        exp_i_q.push_back(idx);
        @(posedge PixelClk); #1;
        rd_req = 1'b0;
    endtask

    task automatic do_write(input int idx, input int x, input int y, input int dx, input int dy);
        bit seen;
        @(posedge PixelClk); #1;
        host_req = 1'b1; host_idx = IW'(idx); host_x = XW'(x); host_y = YW'(y);
        host_dx = VW'(dx); host_dy = VW'(dy);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge PixelClk);
            if (host_ack) seen = 1;
        end
        check("write_acked", int'(seen), 1);
        @(posedge PixelClk); #1;
        host_req = 1'b0;
        if (seen) model_write(idx, x, y, dx, dy);
    endtask

    task automatic do_frame();
        int busy_cyc, done_cnt;
        @(posedge PixelClk); #1 frame_start = 1'b1;
        @(posedge PixelClk); #1 frame_start = 1'b0;
        model_step();
        busy_cyc = 0; done_cnt = 0;
        for (int c = 0; c < N + 4; c++) begin
            @(negedge PixelClk);
            if (busy) busy_cyc++;
            if (update_done) done_cnt++;
        end
        check("busy_cycles", busy_cyc, N + 1);
        check("done_pulses", done_cnt, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        // Reset state
        #23;
        check("rst_host_ack", int'(host_ack), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_update_done", int'(update_done), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_rd_x", int'(rd_x), 0);
        check("rst_rd_y", int'(rd_y), 0);
        nRST = 1'b1;
        do_read(3);

        // Basic motion
        do_write(2, 100, 50, 4, -3);
        do_frame();
        do_read(2);

        // Edge wrap in both directions
        do_write(0, 478, 1, 4, -3);
        do_write(1, 0, 271, -1, 1);
        do_frame();
        do_read(0);
        do_read(1);

        // frame_start and host_req in the same IDLE cycle
        begin
            bit seen_done, early_ack, acked;
            @(posedge PixelClk); #1;
            frame_start = 1'b1; host_req = 1'b1;
            host_idx = IW'(5); host_x = XW'(300); host_y = YW'(200);
            host_dx = VW'(-2); host_dy = VW'(7);
            @(posedge PixelClk); #1 frame_start = 1'b0;
            model_step();
            seen_done = 0; early_ack = 0; acked = 0;
            for (int c = 0; c < N + 6; c++) begin
                @(negedge PixelClk);
                if (seen_done) begin
                    acked = host_ack;
                    break;
                end
                if (host_ack) early_ack = 1;
                if (update_done) seen_done = 1;
            end
            check("coinc_no_early_ack", int'(early_ack), 0);
            check("coinc_done_seen", int'(seen_done), 1);
            check("coinc_ack_after_done", int'(acked), 1);
            @(posedge PixelClk); #1 host_req = 1'b0;
            model_write(5, 300, 200, -2, 7);
            do_read(5);
        end

        // Second frame_start during UPDATE
        begin
            int done_cnt;
            @(posedge PixelClk); #1 frame_start = 1'b1;
            @(posedge PixelClk); #1 frame_start = 1'b0;
            model_step();
            @(posedge PixelClk); #1 frame_start = 1'b1;
            @(posedge PixelClk); #1 frame_start = 1'b0;
            done_cnt = 0;
            for (int c = 0; c < N + 6; c++) begin
                @(negedge PixelClk);
                if (update_done) done_cnt++;
            end
            check("ovr_done_once", done_cnt, 1);
            check("ovr_set", int'(overrun), 1);
            do_frame();
            check("ovr_sticky", int'(overrun), 1);
            do_read(2);
        end

        // Reset during the 3rd UPDATE cycle
        @(posedge PixelClk); #1 frame_start = 1'b1;
        @(posedge PixelClk); #1 frame_start = 1'b0;
        @(posedge PixelClk);
        @(posedge PixelClk); #2;
        nRST = 1'b0;
        #2;
        check("midrst_busy", int'(busy), 0);
        check("midrst_overrun", int'(overrun), 0);
        check("midrst_rd_x", int'(rd_x), 0);
        model_clear();
        @(negedge PixelClk);
        nRST = 1'b1;
        for (int i = 0; i < N; i++) do_read(i);
        do_write(4, 10, 20, 3, -5);
        do_frame();
        do_read(4);

        // Randomised traffic
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 2))
                0: do_write($urandom_range(0, N - 1), $urandom_range(0, H - 1),
                            $urandom_range(0, V - 1), $urandom_range(0, 15) - 8,
                            $urandom_range(0, 15) - 8);
                1: do_frame();
                default: do_read($urandom_range(0, N - 1));
            endcase
        end
        for (int i = 0; i < N; i++) do_read(i);

        repeat (4) @(posedge PixelClk);
        check("scoreboard_drained", exp_x_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
